// File: rtl/anc_seq_pkg.sv
// Shared types and sizing helpers for the ANC start-up sequencer.
package anc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } anc_seq_state_t;

  // Interval counter width: enough bits to hold the largest reload value.
  function automatic int unsigned cnt_width(input int unsigned holdoff,
                                            input int unsigned settle,
                                            input int unsigned div);
    int unsigned m;
    m = holdoff;
    if (settle > m) m = settle;
    if (div > m) m = div;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/anc_interval_counter.sv
// Loadable down-counter; expire flags the last cycle of a loaded interval.
module anc_interval_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // A value of N loaded at edge E expires across edge E+N.
  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/anc_sample_sequencer.sv
// Power-up sequencer (hold-off, ADC enable, settle, filter enable) and
// sample-strobe generator for the ANC datapath.
module anc_sample_sequencer #(
  parameter int unsigned HOLDOFF = 8,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned DIV     = 50,
  parameter int unsigned IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             adc_en,
  output logic             filt_en,
  output logic             ready,
  output logic             sample_tick,
  output logic [IDX_W-1:0] sample_idx
);

  import anc_seq_pkg::*;

  localparam int unsigned CNT_W = cnt_width(HOLDOFF, SETTLE, DIV);

  anc_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0] tick_cnt, tick_cnt_d;
  logic [IDX_W-1:0] sample_idx_d;
  logic             adc_en_d, filt_en_d, ready_d, sample_tick_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expire;

  anc_interval_counter #(
    .CNT_W (CNT_W)
  ) u_interval (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // State, tick count and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_cnt    <= '0;
      adc_en      <= 1'b0;
      filt_en     <= 1'b0;
      ready       <= 1'b0;
      sample_tick <= 1'b0;
      sample_idx  <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt    <= tick_cnt_d;
      adc_en      <= adc_en_d;
      filt_en     <= filt_en_d;
      ready       <= ready_d;
      sample_tick <= sample_tick_d;
      sample_idx  <= sample_idx_d;
    end
  end

  // Enum literal qualified where it collides with the SETTLE parameter.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt;
    adc_en_d      = adc_en;
    filt_en_d     = filt_en;
    ready_d       = ready;
    sample_tick_d = 1'b0;
    sample_idx_d  = sample_idx;
    load          = 1'b0;
    load_val      = '0;

    if (state_q != IDLE && !run) begin
      state_d      = IDLE;
      tick_cnt_d   = '0;
      adc_en_d     = 1'b0;
      filt_en_d    = 1'b0;
      ready_d      = 1'b0;
      sample_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          adc_en_d     = 1'b0;
          filt_en_d    = 1'b0;
          ready_d      = 1'b0;
          sample_idx_d = '0;
          tick_cnt_d   = '0;
          if (run) begin
            state_d  = HOLD;
            load     = 1'b1;
            load_val = CNT_W'(HOLDOFF);
          end
        end
        HOLD: begin
          if (expire) begin
            state_d  = anc_seq_pkg::SETTLE;
            adc_en_d = 1'b1;
            load     = 1'b1;
            load_val = CNT_W'(SETTLE);
          end
        end
        anc_seq_pkg::SETTLE: begin
          if (expire) begin
            state_d    = RUN;
            filt_en_d  = 1'b1;
            ready_d    = 1'b1;
            tick_cnt_d = '0;
            load       = 1'b1;
            load_val   = CNT_W'(DIV);
          end
        end
        RUN: begin
          if (expire) begin
            sample_tick_d = 1'b1;
            sample_idx_d  = tick_cnt;
            tick_cnt_d    = tick_cnt + IDX_W'(1);
            load          = 1'b1;
            load_val      = CNT_W'(DIV);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Scoreboard bench: a timing-equation model pushes expected outputs each edge;
// a negedge monitor pops and compares against two differently sized instances.
module tb_anc_sample_sequencer;

  localparam int A_H = 8, A_S = 16, A_D = 50, A_W = 16;
  localparam int B_H = 8, B_S = 16, B_D = 2,  B_W = 4;

  typedef struct {
    bit active;
    int k;
    int idx;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;

  logic             a_adc, a_filt, a_ready, a_tick;
  logic [A_W-1:0]   a_idx;
  logic             b_adc, b_filt, b_ready, b_tick;
  logic [B_W-1:0]   b_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] qa[$];
  logic [19:0] qb[$];
  mdl_t ma = '{0, 0, 0};
  mdl_t mb = '{0, 0, 0};

  always #5 clk = ~clk;

  anc_sample_sequencer #(
    .HOLDOFF (A_H), .SETTLE (A_S), .DIV (A_D), .IDX_W (A_W)
  ) dut_a (
    .clk (clk), .rst (rst), .run (run),
    .adc_en (a_adc), .filt_en (a_filt), .ready (a_ready),
    .sample_tick (a_tick), .sample_idx (a_idx)
  );

  anc_sample_sequencer #(
    .HOLDOFF (B_H), .SETTLE (B_S), .DIV (B_D), .IDX_W (B_W)
  ) dut_b (
    .clk (clk), .rst (rst), .run (run),
    .adc_en (b_adc), .filt_en (b_filt), .ready (b_ready),
    .sample_tick (b_tick), .sample_idx (b_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs derived from edge distance k since the run-accept edge.
  task automatic mdl_step(input mdl_t mi, input logic r, input logic rn,
                          input int h, input int s, input int d, input int w,
                          output mdl_t mo, output logic [19:0] e);
    int t;
    logic adc, filt, tick;
    mo = mi;
    e  = '0;
    if (!r) begin
      mo.active = 0; mo.k = 0; mo.idx = 0;
    end else if (!mi.active) begin
      if (rn) begin
        mo.active = 1; mo.k = 0;
      end
      mo.idx = 0;
    end else if (!rn) begin
      mo.active = 0; mo.idx = 0;
    end else begin
      mo.k = mi.k + 1;
      t    = mo.k - h - s;
      adc  = (mo.k >= h);
      filt = (t >= 0);
      tick = (t >= d) && (t % d == 0);
      if (tick) mo.idx = (t / d - 1) % (1 << w);
      e = {adc, filt, filt, tick, 16'(mo.idx)};
    end
  endtask

  always @(posedge clk) begin
    mdl_t na, nb;
    logic [19:0] ea, eb;
    mdl_step(ma, rst, run, A_H, A_S, A_D, A_W, na, ea);
    mdl_step(mb, rst, run, B_H, B_S, B_D, B_W, nb, eb);
    ma = na;
    mb = nb;
    qa.push_back(ea);
    qb.push_back(eb);
  end

  always @(negedge clk) begin
    if (qa.size() > 0)
      check("dflt_outputs", 32'({a_adc, a_filt, a_ready, a_tick, 16'(a_idx)}), 32'(qa.pop_front()));
    if (qb.size() > 0)
      check("div2_outputs", 32'({b_adc, b_filt, b_ready, b_tick, 16'(b_idx)}), 32'(qb.pop_front()));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(3);
    rst = 1'b1;
    cycles(2);

    // Full power-up from edge 0, ticks at 74/124 (default) and idx wrap (DIV=2).
    run = 1'b1;
    cycles(130);
    run = 1'b0;
    cycles(5);

    // Drop at edge 15 (mid-SETTLE), re-raise at edge 20.
    run = 1'b1;
    cycles(15);
    run = 1'b0;
    cycles(5);
    run = 1'b1;
    cycles(40);
    run = 1'b0;
    cycles(3);

    // Drop on the edge where default-instance tick idx 3 is due (edge 224).
    run = 1'b1;
    cycles(224);
    run = 1'b0;
    cycles(4);
    run = 1'b1;
    cycles(130);

    // One-edge reset mid-RUN with run held.
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(40);

    // Reset held for 5 edges while run is high.
    rst = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycles(30);

    run = 1'b0;
    cycles(3);
    #1;
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
